// File: rtl/cache_trace_writer.sv
// rtl/cache_trace_writer.sv - serializes cache access records into ASCII trace lines
module cache_trace_writer #(
  parameter bit PREFIX_EN = 1'b1,
  parameter bit HIT_FIELD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_hit,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic        busy,
  output logic [31:0] access_count,
  output logic [31:0] hit_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    SEP   = 3'd4,
    FLAG  = 3'd5,
    EOL   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] addr_q;
  logic        hit_q;
  logic [31:0] access_q, hit_cnt_q;
  logic        capture, advance;
  logic [31:0] addr_src;
  logic        hit_src;
  logic [3:0]  nib;
  logic [7:0]  byte_d;

  assign capture  = req_valid && (state_q == IDLE);
  assign advance  = tx_valid && tx_ready;
  // On the capture edge the record is not latched yet, so the first byte comes straight from the request.
  assign addr_src = capture ? req_addr : addr_q;
  assign hit_src  = capture ? req_hit  : hit_q;

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign access_count = access_q;
  assign hit_count    = hit_cnt_q;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) hex_ascii = 8'h30 + {4'h0, n};
    else           hex_ascii = 8'h57 + {4'h0, n};
  endfunction

  // Next state and nibble index; every non-idle state waits for a byte handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (capture) begin
        state_d = PREFIX_EN ? PFX0 : DIGIT;
        idx_d   = 3'd7;
      end
      PFX0: if (advance) state_d = PFX1;
      PFX1: if (advance) begin
        state_d = DIGIT;
        idx_d   = 3'd7;
      end
      DIGIT: if (advance) begin
        if (idx_q == 3'd0) state_d = HIT_FIELD ? SEP : EOL;
        else               idx_d   = idx_q - 3'd1;
      end
      SEP:  if (advance) state_d = FLAG;
      FLAG: if (advance) state_d = EOL;
      EOL:  if (advance) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pick the nibble that the next DIGIT byte will encode, most significant first.
  always_comb begin
    nib = 4'h0;
    case (idx_d)
      3'd7: nib = addr_src[31:28];
      3'd6: nib = addr_src[27:24];
      3'd5: nib = addr_src[23:20];
      3'd4: nib = addr_src[19:16];
      3'd3: nib = addr_src[15:12];
      3'd2: nib = addr_src[11:8];
      3'd1: nib = addr_src[7:4];
      default: nib = addr_src[3:0];
    endcase
  end

  // Byte for the state being entered; unchanged state gives an unchanged byte, which holds data under backpressure.
  always_comb begin
    byte_d = 8'h00;
    case (state_d)
      PFX0:  byte_d = 8'h30;
      PFX1:  byte_d = 8'h78;
      DIGIT: byte_d = hex_ascii(nib);
      SEP:   byte_d = 8'h20;
      FLAG:  byte_d = hit_src ? 8'h68 : 8'h6D;
      EOL:   byte_d = 8'h0A;
      default: byte_d = 8'h00;
    endcase
  end

  // State, record latch and registered byte outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      addr_q   <= 32'h0;
      hit_q    <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_last  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      if (capture) begin
        addr_q <= req_addr;
        hit_q  <= req_hit;
      end
      tx_valid <= (state_d != IDLE);
      tx_data  <= byte_d;
      tx_last  <= (state_d == EOL);
    end
  end

  // Saturating access and hit counters, bumped at the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_q  <= 32'h0;
      hit_cnt_q <= 32'h0;
    end else if (capture) begin
      if (access_q != 32'hFFFF_FFFF) access_q <= access_q + 32'd1;
      if (req_hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

endmodule
